// File: rtl/sound_glu_pkg.sv
// Shared constants for the sound GLU: register map, CTRL bit positions,
// FSM state encoding and the host-slot offset after each oscillator pulse.
package sound_glu_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DATA    = 2'd1;
  localparam logic [1:0] REG_ADDR_LO = 2'd2;
  localparam logic [1:0] REG_ADDR_HI = 2'd3;

  localparam int CTRL_BUSY = 7;
  localparam int CTRL_TGT  = 6;
  localparam int CTRL_AINC = 5;

  localparam int HOST_SLOT_DELAY = 2;

  typedef enum logic [2:0] {
    IDLE,
    DOC_ACC,
    DOC_CAP,
    RAM_WAIT,
    RAM_ACC,
    RAM_CAP
  } state_e;

endpackage

// File: rtl/sound_glu.sv
// CPU-side glue for the ES5503 DOC and its sound RAM: CTRL/DATA/ADDR regs,
// host-slot RAM arbitration. Optional SOUND_GLU_AUTOINC_EN enables address auto-increment.
module sound_glu
  import sound_glu_pkg::*;
(
  input  logic        CLK_14M,
  input  logic        reset,
  input  logic [1:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        doc_osc_en,
  input  logic [16:0] doc_addr,
  input  logic [7:0]  doc_data_in,
  output logic        doc_wr,
  output logic        doc_host_en,
  output logic [7:0]  doc_reg_addr,
  output logic [7:0]  doc_reg_data,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [3:0]  volume
);

`ifdef SOUND_GLU_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [1:0]  slot_cnt_q, slot_cnt_d;
  logic        tgt_q, ainc_q;
  logic [3:0]  vol_q;
  logic [15:0] addr_q, addr_d;
  logic [15:0] acc_addr_q;
  logic [7:0]  wdata_q;
  logic        acc_wr_q;
  logic [7:0]  latch_q, latch_d;
  logic        busy, start, slot_soon, done;

  logic unused_doc_addr_msb;
  assign unused_doc_addr_msb = doc_addr[16];

  assign busy  = (state_q != IDLE);
  assign start = (cpu_wr | cpu_rd) & (cpu_addr == REG_DATA) & ~busy;

  // Counter reloads on every oscillator pulse; the slot is the cycle it reads 1.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    if (doc_osc_en)              slot_cnt_d = 2'(HOST_SLOT_DELAY);
    else if (slot_cnt_q != 2'd0) slot_cnt_d = slot_cnt_q - 2'd1;
  end
  assign slot_soon = (slot_cnt_d == 2'd1);

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    done    = 1'b0;
    case (state_q)
      IDLE:
        if (start) begin
          if (tgt_q) state_d = slot_soon ? RAM_ACC : RAM_WAIT;
          else       state_d = DOC_ACC;
        end
      DOC_ACC:
        if (acc_wr_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DOC_CAP;
        end
      DOC_CAP: begin
        latch_d = doc_data_in;
        done    = 1'b1;
        state_d = IDLE;
      end
      RAM_WAIT:
        if (slot_soon) state_d = RAM_ACC;
      RAM_ACC:
        if (acc_wr_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RAM_CAP;
        end
      RAM_CAP: begin
        latch_d = ram_dout;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A CPU write to an address byte overrides that byte of the increment.
  always_comb begin
    addr_d = addr_q;
    if (AUTOINC && done && ainc_q) addr_d = addr_q + 16'd1;
    if (cpu_wr && cpu_addr == REG_ADDR_LO) addr_d[7:0]  = cpu_din;
    if (cpu_wr && cpu_addr == REG_ADDR_HI) addr_d[15:8] = cpu_din;
  end

  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      state_q    <= IDLE;
      slot_cnt_q <= 2'd0;
      tgt_q      <= 1'b0;
      ainc_q     <= 1'b0;
      vol_q      <= 4'd0;
      addr_q     <= 16'd0;
      acc_addr_q <= 16'd0;
      wdata_q    <= 8'd0;
      acc_wr_q   <= 1'b0;
      latch_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      addr_q     <= addr_d;
      latch_q    <= latch_d;
      if (cpu_wr && cpu_addr == REG_CTRL) begin
        tgt_q  <= cpu_din[CTRL_TGT];
        ainc_q <= cpu_din[CTRL_AINC];
        vol_q  <= cpu_din[3:0];
      end
      if (start) begin
        acc_addr_q <= addr_q;
        wdata_q    <= cpu_din;
        acc_wr_q   <= cpu_wr;
      end
    end
  end

  always_comb begin
    cpu_dout = 8'd0;
    case (cpu_addr)
      REG_CTRL:    cpu_dout = {busy, tgt_q, ainc_q, 1'b0, vol_q};
      REG_DATA:    cpu_dout = latch_q;
      REG_ADDR_LO: cpu_dout = addr_q[7:0];
      default:     cpu_dout = addr_q[15:8];
    endcase
  end

  assign doc_host_en  = ~reset & (state_q == DOC_ACC);
  assign doc_wr       = doc_host_en & acc_wr_q;
  assign doc_reg_addr = acc_addr_q[7:0];
  assign doc_reg_data = wdata_q;
  assign ram_addr     = (state_q == RAM_ACC) ? acc_addr_q : doc_addr[15:0];
  assign ram_we       = ~reset & (state_q == RAM_ACC) & acc_wr_q;
  assign ram_din      = wdata_q;
  assign volume       = vol_q;

endmodule
